// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: tick-enabled digit stepping, anti-ghost blanking,
// per-frame input snapshot. Optional leading-zero blanking via `define SEG7_LZ_BLANK_EN.
module seg7_scan_ctrl #(
  parameter int N_DIGITS     = 8,
  parameter int TICK_MAX     = 124999,
  parameter int GHOST_CYCLES = 100
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     digit_en,
  input  logic [N_DIGITS-1:0]     dp_in,
  output logic [N_DIGITS-1:0]     an,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic                    frame_start
);

  localparam int TW = $clog2(TICK_MAX + 1);
  localparam int IW = $clog2(N_DIGITS);
  localparam int GW = (GHOST_CYCLES > 1) ? $clog2(GHOST_CYCLES) : 1;

  localparam logic [TW-1:0]       TICK_LAST  = TW'(TICK_MAX);
  localparam logic [IW-1:0]       IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [GW-1:0]       GHOST_LAST = GW'(GHOST_CYCLES - 1);
  localparam logic [N_DIGITS-1:0] DIG_ONE    = N_DIGITS'(1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  state_t                state_q, state_d;
  logic [GW-1:0]         ghost_cnt_q, ghost_cnt_d;
  logic [4*N_DIGITS-1:0] shd_val_q, shd_val_d;
  logic [N_DIGITS-1:0]   shd_en_q, shd_en_d;
  logic [N_DIGITS-1:0]   shd_dp_q, shd_dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_n_q, dp_n_d;
  logic                  frame_start_q, frame_start_d;

  logic                  tick;
  logic                  wrap;
  logic [N_DIGITS-1:0]   en_snap;
  logic [3:0]            cur_nib;
  logic                  cur_en;
  logic                  cur_dp;

  assign tick = (tick_cnt_q == TICK_LAST);
  assign wrap = (idx_q == IDX_LAST);

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

`ifdef SEG7_LZ_BLANK_EN
  // Walk down from the top digit; everything above the first nonzero nibble goes dark.
  always_comb begin : lz_blank
    logic seen;
    seen    = 1'b0;
    en_snap = digit_en;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      if (value[4*i +: 4] != 4'h0) seen = 1'b1;
      if (!seen) en_snap[i] = 1'b0;
    end
  end
`else
  assign en_snap = digit_en;
`endif

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ghost_cnt_d   = ghost_cnt_q;
    shd_val_d     = shd_val_q;
    shd_en_d      = shd_en_q;
    shd_dp_d      = shd_dp_q;
    frame_start_d = 1'b0;
    if (tick) begin
      idx_d       = wrap ? '0 : idx_q + 1'b1;
      state_d     = ST_BLANK;
      ghost_cnt_d = '0;
      if (wrap) begin
        shd_val_d     = value;
        shd_en_d      = en_snap;
        shd_dp_d      = dp_in;
        frame_start_d = 1'b1;
      end
    end else if (state_q == ST_BLANK) begin
      if (ghost_cnt_q == GHOST_LAST) begin
        state_d = ST_DRIVE;
      end else begin
        ghost_cnt_d = ghost_cnt_q + 1'b1;
      end
    end
  end

  // Outputs are derived from next-state values so they change on the same edge as the slot.
  always_comb begin
    cur_nib = 4'h0;
    cur_en  = 1'b0;
    cur_dp  = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        cur_nib = shd_val_d[4*i +: 4];
        cur_en  = shd_en_d[i];
        cur_dp  = shd_dp_d[i];
      end
    end
  end

  always_comb begin
    an_d   = '1;
    seg_d  = 7'h7F;
    dp_n_d = 1'b1;
    if (state_d == ST_DRIVE && cur_en) begin
      an_d   = ~(DIG_ONE << idx_d);
      seg_d  = hex_to_seg(cur_nib);
      dp_n_d = ~cur_dp;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      tick_cnt_q    <= '0;
      idx_q         <= IDX_LAST;
      state_q       <= ST_BLANK;
      ghost_cnt_q   <= '0;
      shd_val_q     <= '0;
      shd_en_q      <= '0;
      shd_dp_q      <= '0;
      an_q          <= '1;
      seg_q         <= 7'h7F;
      dp_n_q        <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      idx_q         <= idx_d;
      state_q       <= state_d;
      ghost_cnt_q   <= ghost_cnt_d;
      shd_val_q     <= shd_val_d;
      shd_en_q      <= shd_en_d;
      shd_dp_q      <= shd_dp_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_n_q        <= dp_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp_n        = dp_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

  logic        clk_in;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_start;

  seg7_scan_ctrl #(
    .N_DIGITS    (4),
    .TICK_MAX    (9),
    .GHOST_CYCLES(2)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .value      (value),
    .digit_en   (digit_en),
    .dp_in      (dp_in),
    .an         (an),
    .seg        (seg),
    .dp_n       (dp_n),
    .frame_start(frame_start)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    string      tag;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_m;
  int   total = 0;
  int   bad   = 0;

  function automatic void push(input string tag, input logic [3:0] a, input logic [6:0] s,
                               input logic d, input logic f);
    exp_t e;
    e.tag  = tag;
    e.an   = a;
    e.seg  = s;
    e.dp_n = d;
    e.fs   = f;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk_in) begin
    if (exp_q.size() > 0) begin
      e_m = exp_q.pop_front();
      total++;
      if (an !== e_m.an || seg !== e_m.seg || dp_n !== e_m.dp_n || frame_start !== e_m.fs) begin
        bad++;
        $display("FAIL %s: got an=%h seg=%h dp_n=%b fs=%b, want an=%h seg=%h dp_n=%b fs=%b",
                 e_m.tag, an, seg, dp_n, frame_start, e_m.an, e_m.seg, e_m.dp_n, e_m.fs);
      end
    end
  end

  task automatic blank_cycle(input string tag);
    @(posedge clk_in); #2;
    push(tag, 4'hF, 7'h7F, 1'b1, 1'b0);
  endtask

  task automatic run_slot(input string tag, input logic [3:0] a, input logic [6:0] s,
                          input logic d, input logic fs);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_in); #2;
      if (c < 2) push(tag, 4'hF, 7'h7F, 1'b1, (c == 0) ? fs : 1'b0);
      else       push(tag, a, s, d, 1'b0);
    end
  endtask

  task automatic boot(input string tag);
    @(posedge clk_in); #2;
    reset = 1'b1;
    push(tag, 4'hF, 7'h7F, 1'b1, 1'b0);
    repeat (9) blank_cycle(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000ns, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    value    = 16'h1234;
    digit_en = 4'hF;
    dp_in    = 4'h0;
    #1 reset = 1'b0;
    #1;
    if (an !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1 || frame_start !== 1'b0) begin
      bad++;
      $display("FAIL por: got an=%h seg=%h dp_n=%b fs=%b, want an=f seg=7f dp_n=1 fs=0",
               an, seg, dp_n, frame_start);
    end
    repeat (3) blank_cycle("reset");
    boot("boot");

    run_slot("f1d0", 4'hE, 7'h19, 1'b1, 1'b1);
    run_slot("f1d1", 4'hD, 7'h30, 1'b1, 1'b0);
    run_slot("f1d2", 4'hB, 7'h24, 1'b1, 1'b0);
    run_slot("f1d3", 4'h7, 7'h79, 1'b1, 1'b0);

    run_slot("f2d0", 4'hE, 7'h19, 1'b1, 1'b1);
    run_slot("f2d1", 4'hD, 7'h30, 1'b1, 1'b0);
    run_slot("f2d2", 4'hB, 7'h24, 1'b1, 1'b0);
    value = 16'hABCD;
    run_slot("f2d3", 4'h7, 7'h79, 1'b1, 1'b0);

    run_slot("f3d0", 4'hE, 7'h21, 1'b1, 1'b1);
    run_slot("f3d1", 4'hD, 7'h46, 1'b1, 1'b0);
    run_slot("f3d2", 4'hB, 7'h03, 1'b1, 1'b0);
    digit_en = 4'b0101;
    dp_in    = 4'b0001;
    run_slot("f3d3", 4'h7, 7'h08, 1'b1, 1'b0);

    run_slot("f4d0", 4'hE, 7'h21, 1'b0, 1'b1);
    run_slot("f4d1", 4'hF, 7'h7F, 1'b1, 1'b0);
    run_slot("f4d2", 4'hB, 7'h03, 1'b1, 1'b0);
    run_slot("f4d3", 4'hF, 7'h7F, 1'b1, 1'b0);

    for (int c = 0; c < 5; c++) begin
      @(posedge clk_in); #2;
      if (c < 2) push("f5d0", 4'hF, 7'h7F, 1'b1, (c == 0));
      else       push("f5d0", 4'hE, 7'h21, 1'b0, 1'b0);
    end
    @(posedge clk_in); #2;
    reset = 1'b0;
    #1;
    if (an !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1 || frame_start !== 1'b0) begin
      bad++;
      $display("FAIL rstasync: got an=%h seg=%h dp_n=%b fs=%b, want an=f seg=7f dp_n=1 fs=0",
               an, seg, dp_n, frame_start);
    end
    push("rstmid", 4'hF, 7'h7F, 1'b1, 1'b0);
    value    = 16'h0070;
    digit_en = 4'hF;
    dp_in    = 4'h0;
    repeat (2) blank_cycle("rstmid");
    boot("reboot");

    run_slot("r1d0", 4'hE, 7'h40, 1'b1, 1'b1);
    run_slot("r1d1", 4'hD, 7'h78, 1'b1, 1'b0);
`ifdef SEG7_LZ_BLANK_EN
    run_slot("r1d2", 4'hF, 7'h7F, 1'b1, 1'b0);
    value = 16'h0000;
    run_slot("r1d3", 4'hF, 7'h7F, 1'b1, 1'b0);
    run_slot("r2d0", 4'hE, 7'h40, 1'b1, 1'b1);
    run_slot("r2d1", 4'hF, 7'h7F, 1'b1, 1'b0);
    run_slot("r2d2", 4'hF, 7'h7F, 1'b1, 1'b0);
    value = 16'h5689;
    run_slot("r2d3", 4'hF, 7'h7F, 1'b1, 1'b0);
`else
    run_slot("r1d2", 4'hB, 7'h40, 1'b1, 1'b0);
    value = 16'h0000;
    run_slot("r1d3", 4'h7, 7'h40, 1'b1, 1'b0);
    run_slot("r2d0", 4'hE, 7'h40, 1'b1, 1'b1);
    run_slot("r2d1", 4'hD, 7'h40, 1'b1, 1'b0);
    run_slot("r2d2", 4'hB, 7'h40, 1'b1, 1'b0);
    value = 16'h5689;
    run_slot("r2d3", 4'h7, 7'h40, 1'b1, 1'b0);
`endif

    run_slot("r3d0", 4'hE, 7'h10, 1'b1, 1'b1);
    run_slot("r3d1", 4'hD, 7'h00, 1'b1, 1'b0);
    run_slot("r3d2", 4'hB, 7'h02, 1'b1, 1'b0);
    value = 16'hEFEF;
    run_slot("r3d3", 4'h7, 7'h12, 1'b1, 1'b0);

    run_slot("r4d0", 4'hE, 7'h0E, 1'b1, 1'b1);
    run_slot("r4d1", 4'hD, 7'h06, 1'b1, 1'b0);
    run_slot("r4d2", 4'hB, 7'h0E, 1'b1, 1'b0);
    run_slot("r4d3", 4'h7, 7'h06, 1'b1, 1'b0);

    @(negedge clk_in); #1;
    if (total == 0 || bad != 0) begin
      $display("FAIL summary: got total=%0d bad=%0d, want total>0 bad=0", total, bad);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
